// File: rtl/mdu_iterative_if.sv
// Operand/result bundle between the EX stage and the iterative multiply/divide unit.
// The EX stage drives the master side; the MDU implements the slave side.
interface mdu_iterative_if #(
  parameter int WIDTH = 32
);
  logic             Start;
  logic [2:0]       Op;
  logic [WIDTH-1:0] OperandA;
  logic [WIDTH-1:0] OperandB;
  logic             Cancel;
  logic             ReadHILO;
  logic             Busy;
  logic             Done;
  logic             StallReq;
  logic [WIDTH-1:0] HI;
  logic [WIDTH-1:0] LO;

  modport master (
    output Start, Op, OperandA, OperandB, Cancel, ReadHILO,
    input  Busy, Done, StallReq, HI, LO
  );

  modport slave (
    input  Start, Op, OperandA, OperandB, Cancel, ReadHILO,
    output Busy, Done, StallReq, HI, LO
  );
endinterface

// File: rtl/mdu_iterative.sv
// Iterative radix-2 multiply/divide unit owning the HI/LO pair for the EX stage.
// state | meaning
// IDLE  | waiting for Start; MTHI/MTLO written here
// CALC  | one shift-add or restoring-divide step per cycle
// FIX   | sign correction and HI/LO write
module mdu_iterative #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input logic            clk,
  input logic            rst,
  mdu_iterative_if.slave bus
);
  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               is_div_q, is_div_d;
  logic               neg_q, neg_d;
  logic               rneg_q, rneg_d;
  logic               done_q, done_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH:0]     rem_q, rem_d;
  logic [WIDTH:0]     b_q, b_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;

  logic               signed_op, a_neg, b_neg, b_zero;
  logic [WIDTH:0]     a_ext, b_ext, a_mag, b_mag;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH+1:0]   div_shift;
  logic [WIDTH:0]     div_diff;
  logic               div_qbit;
  logic [2*WIDTH-1:0] mul_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  // Magnitudes are taken in WIDTH+1 bits so the most negative operand stays exact.
  always_comb begin
    signed_op = (bus.Op == OP_MULT) || (bus.Op == OP_DIV);
    a_neg     = signed_op & bus.OperandA[WIDTH-1];
    b_neg     = signed_op & bus.OperandB[WIDTH-1];
    b_zero    = (bus.OperandB == '0);
    a_ext     = {a_neg, bus.OperandA};
    b_ext     = {b_neg, bus.OperandB};
    a_mag     = a_neg ? -a_ext : a_ext;
    b_mag     = b_neg ? -b_ext : b_ext;
  end

  always_comb begin
    mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + b_q;
    div_shift = {rem_q, acc_q[WIDTH-1]};
    div_qbit  = (div_shift >= {1'b0, b_q});
    div_diff  = div_shift[WIDTH:0] - b_q;
    mul_fix   = neg_q ? -acc_q : acc_q;
    quo_fix   = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    rem_fix   = rneg_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    is_div_d = is_div_q;
    neg_d    = neg_q;
    rneg_d   = rneg_q;
    acc_d    = acc_q;
    rem_d    = rem_q;
    b_d      = b_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
    if (bus.Cancel) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.Start) begin
            if (bus.Op == OP_MTHI) begin
              hi_d = bus.OperandA;
            end else if (bus.Op == OP_MTLO) begin
              lo_d = bus.OperandA;
            end else if (bus.Op <= OP_DIVU) begin
              state_d  = CALC;
              cnt_d    = '0;
              is_div_d = bus.Op[1];
              // A zero divisor must yield an all-ones quotient, so never negate it.
              neg_d    = (a_neg ^ b_neg) & ~(bus.Op[1] & b_zero);
              rneg_d   = a_neg;
              acc_d    = {{(WIDTH-1){1'b0}}, a_mag};
              rem_d    = '0;
              b_d      = b_mag;
            end
          end
        end
        CALC: begin
          cnt_d = cnt_q + CNT_W'(1);
          if (is_div_q) begin
            rem_d = div_qbit ? div_diff : div_shift[WIDTH:0];
            acc_d = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-2:0], div_qbit};
          end else if (acc_q[0]) begin
            acc_d = {mul_sum, acc_q[WIDTH-1:1]};
          end else begin
            acc_d = {1'b0, acc_q[2*WIDTH-1:1]};
          end
          if (cnt_q == CNT_W'(WIDTH-1)) begin
            state_d = FIX;
          end
        end
        FIX: begin
          state_d = IDLE;
          done_d  = 1'b1;
          if (is_div_q) begin
            hi_d = rem_fix;
            lo_d = quo_fix;
          end else begin
            hi_d = mul_fix[2*WIDTH-1:WIDTH];
            lo_d = mul_fix[WIDTH-1:0];
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      is_div_q <= 1'b0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      done_q   <= 1'b0;
      acc_q    <= '0;
      rem_q    <= '0;
      b_q      <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      is_div_q <= is_div_d;
      neg_q    <= neg_d;
      rneg_q   <= rneg_d;
      done_q   <= done_d;
      acc_q    <= acc_d;
      rem_q    <= rem_d;
      b_q      <= b_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  assign bus.Busy     = (state_q != IDLE);
  assign bus.Done     = done_q;
  assign bus.StallReq = bus.Busy & (bus.Start | bus.ReadHILO);
  assign bus.HI       = hi_q;
  assign bus.LO       = lo_q;
endmodule

// File: tb/tb_mdu_iterative.sv
// Self-checking bench: directed 32-bit vectors, multi-cycle corner sequences,
// and a WIDTH=8 instance compared against an integer reference model.
module tb_mdu_iterative;
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;

  mdu_iterative_if #(.WIDTH(32)) if32 ();
  mdu_iterative_if #(.WIDTH(8))  if8 ();

  mdu_iterative #(.WIDTH(32)) u_mdu32 (.clk(clk), .rst(rst_n), .bus(if32));
  mdu_iterative #(.WIDTH(8))  u_mdu8  (.clk(clk), .rst(rst_n), .bus(if8));

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  vec_t       vecs [13];
  logic [7:0] vals [14];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called at a negedge with the 32-bit unit idle; returns at the first idle negedge.
  task automatic run32(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       output int cyc, output logic dn);
    if32.Start = 1'b1; if32.Op = op; if32.OperandA = a; if32.OperandB = b;
    @(negedge clk);
    if32.Start = 1'b0;
    cyc = 0;
    while (if32.Busy && cyc < 100) begin
      cyc++;
      @(negedge clk);
    end
    dn = if32.Done;
  endtask

  task automatic run8(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                      output int cyc, output logic dn);
    if8.Start = 1'b1; if8.Op = op; if8.OperandA = a; if8.OperandB = b;
    @(negedge clk);
    if8.Start = 1'b0;
    cyc = 0;
    while (if8.Busy && cyc < 50) begin
      cyc++;
      @(negedge clk);
    end
    dn = if8.Done;
  endtask

  function automatic logic [15:0] model8(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    int sa, sb, q, r, res;
    sa  = int'($signed(a));
    sb  = int'($signed(b));
    res = 0;
    case (op)
      3'd0: res = sa * sb;
      3'd1: res = int'(a) * int'(b);
      3'd2: begin
        if (b == 8'd0) return {a, 8'hFF};
        q = sa / sb; r = sa % sb;
        res = (r << 8) | (q & 255);
      end
      default: begin
        if (b == 8'd0) return {a, 8'hFF};
        q = int'(a) / int'(b); r = int'(a) % int'(b);
        res = (r << 8) | (q & 255);
      end
    endcase
    return res[15:0];
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int   cyc;
    logic dn;
    logic saw_done;

    if32.Start = 1'b0; if32.Op = 3'd0; if32.OperandA = '0; if32.OperandB = '0;
    if32.Cancel = 1'b0; if32.ReadHILO = 1'b0;
    if8.Start = 1'b0; if8.Op = 3'd0; if8.OperandA = '0; if8.OperandB = '0;
    if8.Cancel = 1'b0; if8.ReadHILO = 1'b0;

    vecs[0]  = '{3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
    vecs[1]  = '{3'd0, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1};
    vecs[2]  = '{3'd2, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[3]  = '{3'd3, 32'h00000007, 32'h00000000, 32'h00000007, 32'hFFFFFFFF};
    vecs[4]  = '{3'd2, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
    vecs[5]  = '{3'd3, 32'h00000064, 32'h00000007, 32'h00000002, 32'h0000000E};
    vecs[6]  = '{3'd0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
    vecs[7]  = '{3'd2, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
    vecs[8]  = '{3'd2, 32'hFFFFFFF8, 32'h00000000, 32'hFFFFFFF8, 32'hFFFFFFFF};
    vecs[9]  = '{3'd1, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780};
    vecs[10] = '{3'd0, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFF9};
    vecs[11] = '{3'd2, 32'h80000000, 32'h00000000, 32'h80000000, 32'hFFFFFFFF};
    vecs[12] = '{3'd3, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'hFFFFFFFF};

    vals = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h07, 8'h7F, 8'h80, 8'h81,
             8'hFF, 8'hFE, 8'h55, 8'hAA, 8'h10, 8'hC3};

    // Reset state, with requests present while reset is held.
    repeat (3) @(negedge clk);
    if32.Start = 1'b1; if32.ReadHILO = 1'b1;
    #1;
    chk("rst_hi",    64'(if32.HI), 64'd0);
    chk("rst_lo",    64'(if32.LO), 64'd0);
    chk("rst_busy",  64'(if32.Busy), 64'd0);
    chk("rst_done",  64'(if32.Done), 64'd0);
    chk("rst_stall", 64'(if32.StallReq), 64'd0);
    if32.Start = 1'b0; if32.ReadHILO = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // MTHI then MTLO
    if32.Start = 1'b1; if32.Op = 3'd4; if32.OperandA = 32'h1234;
    @(negedge clk);
    chk("mthi_hi",   64'(if32.HI), 64'h1234);
    chk("mthi_busy", 64'(if32.Busy), 64'd0);
    if32.Op = 3'd5; if32.OperandA = 32'h5678;
    @(negedge clk);
    if32.Start = 1'b0;
    chk("mtlo_lo",   64'(if32.LO), 64'h5678);
    chk("mtlo_hi",   64'(if32.HI), 64'h1234);
    chk("mtlo_busy", 64'(if32.Busy), 64'd0);
    chk("mtlo_done", 64'(if32.Done), 64'd0);

    // Directed arithmetic vectors
    for (int k = 0; k < 13; k++) begin
      run32(vecs[k].op, vecs[k].a, vecs[k].b, cyc, dn);
      chk($sformatf("v%0d_busy_cycles", k), 64'(cyc), 64'd33);
      chk($sformatf("v%0d_done", k), 64'(dn), 64'd1);
      chk($sformatf("v%0d_hi", k), 64'(if32.HI), 64'(vecs[k].hi));
      chk($sformatf("v%0d_lo", k), 64'(if32.LO), 64'(vecs[k].lo));
      @(negedge clk);
      chk($sformatf("v%0d_done_width", k), 64'(if32.Done), 64'd0);
    end

    // DIVU with ReadHILO held and a second Start from busy cycle 5
    if32.Start = 1'b1; if32.Op = 3'd3; if32.OperandA = 32'd100; if32.OperandB = 32'd7;
    @(negedge clk);
    if32.Start = 1'b0; if32.ReadHILO = 1'b1;
    cyc = 0;
    while (if32.Busy && cyc < 100) begin
      cyc++;
      if (cyc == 5) begin
        if32.Start = 1'b1; if32.Op = 3'd1; if32.OperandA = 32'd3; if32.OperandB = 32'd4;
      end
      #1;
      chk($sformatf("stall_c%0d", cyc), 64'(if32.StallReq), 64'd1);
      @(negedge clk);
    end
    chk("stall_busy_cycles", 64'(cyc), 64'd33);
    chk("stall_done",        64'(if32.Done), 64'd1);
    chk("stall_done_stall",  64'(if32.StallReq), 64'd0);
    chk("stall_hi",          64'(if32.HI), 64'd2);
    chk("stall_lo",          64'(if32.LO), 64'd14);
    if32.ReadHILO = 1'b0;
    @(negedge clk);
    if32.Start = 1'b0;
    chk("b2b_accepted", 64'(if32.Busy), 64'd1);
    cyc = 0;
    while (if32.Busy && cyc < 100) begin
      cyc++;
      @(negedge clk);
    end
    chk("b2b_busy_cycles", 64'(cyc), 64'd33);
    chk("b2b_done", 64'(if32.Done), 64'd1);
    chk("b2b_hi",   64'(if32.HI), 64'd0);
    chk("b2b_lo",   64'(if32.LO), 64'd12);

    // MULT cancelled at busy cycle 10
    if32.Start = 1'b1; if32.Op = 3'd0; if32.OperandA = 32'hFFFFFFFD; if32.OperandB = 32'd5;
    @(negedge clk);
    if32.Start = 1'b0;
    repeat (9) @(negedge clk);
    chk("cancel_busy_before", 64'(if32.Busy), 64'd1);
    if32.Cancel = 1'b1;
    @(negedge clk);
    if32.Cancel = 1'b0;
    chk("cancel_idle", 64'(if32.Busy), 64'd0);
    saw_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (if32.Done) saw_done = 1'b1;
      @(negedge clk);
    end
    chk("cancel_no_done", 64'(saw_done), 64'd0);
    chk("cancel_hi", 64'(if32.HI), 64'd0);
    chk("cancel_lo", 64'(if32.LO), 64'd12);

    // Cancel together with Start: nothing written or started
    if32.Cancel = 1'b1; if32.Start = 1'b1; if32.Op = 3'd4; if32.OperandA = 32'hDEAD;
    @(negedge clk);
    chk("cancel_mthi_hi", 64'(if32.HI), 64'd0);
    if32.Op = 3'd0; if32.OperandA = 32'd9; if32.OperandB = 32'd9;
    @(negedge clk);
    chk("cancel_mult_busy", 64'(if32.Busy), 64'd0);
    if32.Cancel = 1'b0; if32.Start = 1'b0;

    // Reserved opcodes
    if32.Start = 1'b1; if32.Op = 3'd6; if32.OperandA = 32'hFFFF;
    @(negedge clk);
    if32.Op = 3'd7;
    @(negedge clk);
    if32.Start = 1'b0;
    chk("rsv_busy", 64'(if32.Busy), 64'd0);
    chk("rsv_hi",   64'(if32.HI), 64'd0);
    chk("rsv_lo",   64'(if32.LO), 64'd12);

    // Reset at busy cycle 20 of a DIV
    if32.Start = 1'b1; if32.Op = 3'd4; if32.OperandA = 32'h1234;
    @(negedge clk);
    if32.Op = 3'd2; if32.OperandA = 32'hFFFFFFF9; if32.OperandB = 32'd2;
    @(negedge clk);
    if32.Start = 1'b0;
    repeat (19) @(negedge clk);
    if32.ReadHILO = 1'b1;
    #1;
    chk("midrst_busy_before",  64'(if32.Busy), 64'd1);
    chk("midrst_stall_before", 64'(if32.StallReq), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst_busy",  64'(if32.Busy), 64'd0);
    chk("midrst_done",  64'(if32.Done), 64'd0);
    chk("midrst_stall", 64'(if32.StallReq), 64'd0);
    chk("midrst_hi",    64'(if32.HI), 64'd0);
    chk("midrst_lo",    64'(if32.LO), 64'd0);
    if32.ReadHILO = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // WIDTH=8 instance against the reference model
    for (int op = 0; op < 4; op++) begin
      for (int i = 0; i < 14; i++) begin
        for (int j = 0; j < 14; j++) begin
          run8(3'(op), vals[i], vals[j], cyc, dn);
          chk($sformatf("w8_op%0d_%h_%h_cycles", op, vals[i], vals[j]), 64'(cyc), 64'd9);
          chk($sformatf("w8_op%0d_%h_%h_done", op, vals[i], vals[j]), 64'(dn), 64'd1);
          chk($sformatf("w8_op%0d_%h_%h_hilo", op, vals[i], vals[j]),
              64'({if8.HI, if8.LO}), 64'(model8(3'(op), vals[i], vals[j])));
        end
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
